// File: rtl/adc_pkg.sv
// Shared widths, types and a block-length helper for the ADC sample capture path.
package adc_pkg;

  localparam int DW           = 10;
  localparam int DEPTH_LOG2   = 3;
  localparam int MAX_AVG_LOG2 = 3;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int ACC_W        = DW + MAX_AVG_LOG2;
  localparam int AVG_SEL_W    = 2;

  typedef logic [DW-1:0]           sample_t;
  typedef logic [DEPTH_LOG2:0]     level_t;
  typedef logic [ACC_W-1:0]        acc_t;
  typedef logic [MAX_AVG_LOG2-1:0] cnt_t;
  typedef logic [AVG_SEL_W-1:0]    avg_sel_t;

  // Sample index (0-based) that closes a block of 2**k samples.
  function automatic cnt_t block_last(input avg_sel_t k);
    block_last = cnt_t'((1 << k) - 1);
  endfunction

endpackage

// File: rtl/adc_sample_fifo_if.sv
// ADC-to-FIFO data path and FIFO read side, bundled for the capture block.
interface adc_sample_fifo_if;
  import adc_pkg::*;

  // Handshake: adc_valid is a level; one sample is taken per rising edge while
  // adc_result is held stable. rd_en is a one-cycle pop request; the popped word
  // appears on rd_data with a single-cycle rd_valid pulse on the following cycle,
  // and an rd_en on an empty FIFO is ignored (no rd_valid, rd_data holds).
  logic    adc_valid;
  sample_t adc_result;
  logic    rd_en;
  sample_t rd_data;
  logic    rd_valid;
  logic    empty;
  logic    full;
  level_t  level;
  logic    ovf;
  logic    irq;

  modport master (
    output adc_valid, adc_result, rd_en,
    input  rd_data, rd_valid, empty, full, level, ovf, irq
  );

  modport slave (
    input  adc_valid, adc_result, rd_en,
    output rd_data, rd_valid, empty, full, level, ovf, irq
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with level counter, registered read port and sticky overflow.
module sync_fifo #(
  parameter int W  = 10,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          pop_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // The level counter alone decides empty/full; pointers only address storage.
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clr;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop) && !clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= do_pop;
      if (do_pop) begin
        pop_data <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
      if (push && !do_push) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// Captures ADC results on adc_valid rising edges, block-averages them and queues the words.
module adc_sample_fifo
  import adc_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     en,
  input  avg_sel_t avg_sel,
  input  logic     clr,
  input  level_t   thresh,
  adc_sample_fifo_if.slave bus
);

  logic     adc_valid_q;
  acc_t     acc;
  cnt_t     cnt;
  avg_sel_t k_lat;
  avg_sel_t k_eff;
  acc_t     sum;
  logic     take;
  logic     last;
  logic     push;
  sample_t  avg_word;
  logic     irq_q;

  assign take = bus.adc_valid && !adc_valid_q && en;
  // The first sample of a block uses the live avg_sel; later samples use the latched copy.
  assign k_eff    = (cnt == '0) ? avg_sel : k_lat;
  assign sum      = acc + acc_t'(bus.adc_result);
  assign last     = (cnt == block_last(k_eff));
  assign avg_word = sample_t'(sum >> k_eff);
  assign push     = take && last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_valid_q <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      k_lat       <= '0;
    end else begin
      adc_valid_q <= bus.adc_valid;
      if (clr || !en) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        k_lat <= k_eff;
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Threshold zero disables the interrupt entirely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (bus.level >= thresh) && (thresh != '0);
    end
  end

  assign bus.irq = irq_q;

  sync_fifo #(
    .W  (DW),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .push      (push),
    .push_data (avg_word),
    .pop       (bus.rd_en),
    .pop_data  (bus.rd_data),
    .pop_valid (bus.rd_valid),
    .empty     (bus.empty),
    .full      (bus.full),
    .level     (bus.level),
    .ovf       (bus.ovf)
  );

endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
Downstream consumer of the SAR ADC conversion stream. It captures each 10-bit result when the ADC asserts valid, and optionally averages blocks of 1/2/4/8 samples. Averaged words go into an 8-entry FIFO. Software or a logic-analyzer master drains the FIFO through a simple read strobe, and a level threshold raises an interrupt.

Parameters:
DW, 10, ADC result width
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 = 8 entries
MAX_AVG_LOG2, 3, largest averaging exponent; accumulator width = DW+MAX_AVG_LOG2 = 13

Ports:
clk  in  1  single system clock; same clock that drives the ADC
rstn  in  1  asynchronous active-low reset
en  in  1  capture enable
avg_sel  in  2  averaging exponent; block of 2**avg_sel samples
clr  in  1  synchronous flush pulse
adc_valid  in  1  ADC conversion-done flag; level, may stay high for several cycles
adc_result  in  DW  ADC result; stable while adc_valid is high
rd_en  in  1  pop request, one cycle per word
rd_data  out  DW  popped word
rd_valid  out  1  rd_data is fresh this cycle
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  DEPTH_LOG2+1  current entry count, 0..8
thresh  in  DEPTH_LOG2+1  interrupt level
ovf  out  1  sticky overflow flag
irq  out  1  level-based interrupt

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. All flops clear on reset.
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, level=0, ovf=0, irq=0. Internal accumulator, sample counter and rising-edge register are also 0.
- Sample capture: one sample per rising edge of adc_valid (registered previous value). The sample is taken in the cycle where adc_valid=1 and its previous value was 0. A held-high adc_valid yields exactly one sample.
- en gating: samples are taken only while en=1. en=0 clears the accumulator and sample counter. FIFO contents are kept and stay readable.
- Block start: avg_sel is latched at the first sample of each block. Changing avg_sel mid-block has no effect until the next block.
- Accumulation: the accumulator is 13 bits and adds zero-extended samples, so it cannot overflow (8*1023 = 8184).
- Block completion: on the 2**k-th sample (k = latched avg_sel), the result (acc + sample) >> k is pushed. The shift truncates. The accumulator and counter then reset.
- Push timing: the push occurs in the cycle after the capturing edge. Latency from the adc_valid rising edge to the level increment is 1 cycle when k=0.
- Pop: rd_en=1 with FIFO not empty drives rd_data = head and rd_valid=1 on the next cycle. rd_en while empty gives rd_valid=0 and rd_data holds its previous value. rd_valid is a single-cycle pulse.
- Overflow: a push while full with no pop in the same cycle drops the word and sets ovf. ovf stays set until clr or reset.
- Simultaneous push and pop:
  - When full: both succeed, level is unchanged, ovf is not set.
  - When empty: only the push takes effect, rd_valid=0.
  - Otherwise: level is unchanged.
- Pointers: read and write pointers are DEPTH_LOG2 bits and wrap 7 -> 0. The separate level counter is the single source for empty and full: empty = (level==0), full = (level==8).
- clr: takes priority over push and pop in the same cycle. It zeroes the pointers, level, accumulator, counter and ovf. rd_valid is 0 in the next cycle.
- irq: registered. irq = (level >= thresh) && (thresh != 0), recomputed every cycle from the updated level. irq stays low while thresh=0.
- Mid-operation reset: an asynchronous rstn assertion discards the partial block and all FIFO data immediately.

Decomposition:
- Shared package adc_pkg: DW, DEPTH_LOG2, MAX_AVG_LOG2, and typedef sample_t (logic [DW-1:0]).
- Sub-module sync_fifo holds the storage array, pointers, level, empty, full and overflow detect. It has a push/pop interface and is reusable elsewhere.
- The top level contains the edge detect, accumulator and irq logic.

Test Plan:
- Reset and single sample: reset, en=1, avg_sel=0, adc_valid held high 5 cycles with result 0x2A5 -> exactly one entry; rd_en gives rd_data=0x2A5 with rd_valid 1 cycle later; empty=1 afterwards.
- Averaging and mid-block change: avg_sel=2, samples 100, 101, 102, 104 -> one entry, value 101 (407>>2, truncated). Changing avg_sel to 0 after sample 2 still produces a single averaged word.
- Overflow: push 9 words (0..8) with avg_sel=0 and no reads -> full=1 after 8, ovf=1 after the 9th. Draining yields 0..7 in order; ovf stays 1 until a clr pulse.
- Simultaneous full push and pop: at level=8, a sample edge and rd_en coincide -> level stays 8, ovf=0, the popped word is the oldest.
- Empty read and wrap: rd_en on empty -> rd_valid=0. Then run 20 push/pop pairs -> pointers wrap and data order is preserved.
- irq, clr and en: thresh=3, push 3 -> irq=1 one cycle after level reaches 3. One pop -> irq=0. clr with a concurrent push -> level=0. en=0 mid-block -> no partial word is ever pushed.
